// File: rtl/q_box_inv_if.sv
// Request/response handshake bundle for the q-box inverter: byte in, byte out.
interface q_box_inv_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/q_box_inv.sv
// Inverse Twofish q0/q1 permutation: a 256-cycle sweep fills table[q(c)] = c, then serves
// 1-cycle lookups. Define Q_BOX_INV_SELFCHECK_EN to add the sticky chk_err forward re-check.
module q_box_inv #(
    parameter int q = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    q_box_inv_if.slave  bus_if,
    output logic        init_done
`ifdef Q_BOX_INV_SELFCHECK_EN
    ,
    output logic        chk_err
`endif
);
    // t-box nibble tables, entry 0 in the most significant nibble
    localparam logic [63:0] Q0T0 = 64'h817D6F320B59ECA4;
    localparam logic [63:0] Q0T1 = 64'hECB81235F4A6709D;
    localparam logic [63:0] Q0T2 = 64'hBA5E6D90C8F32471;
    localparam logic [63:0] Q0T3 = 64'hD7F4126E9B3085CA;
    localparam logic [63:0] Q1T0 = 64'h28BDF76E31940AC5;
    localparam logic [63:0] Q1T1 = 64'h1E2B4C376DA5F908;
    localparam logic [63:0] Q1T2 = 64'h4C75169A0ED82B3F;
    localparam logic [63:0] Q1T3 = 64'hB951C3DE647F208A;

    function automatic logic [3:0] tbox(input logic [1:0] k, input logic [3:0] n);
        logic [63:0] t;
        logic [63:0] s;
        case (k)
            2'd0:    t = (q == 0) ? Q0T0 : Q1T0;
            2'd1:    t = (q == 0) ? Q0T1 : Q1T1;
            2'd2:    t = (q == 0) ? Q0T2 : Q1T2;
            default: t = (q == 0) ? Q0T3 : Q1T3;
        endcase
        s = t >> {~n, 2'b00};
        return s[3:0];
    endfunction

    function automatic logic [7:0] fwd(input logic [7:0] x);
        logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
        a0 = x[7:4];
        b0 = x[3:0];
        a1 = a0 ^ b0;
        b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
        a2 = tbox(2'd0, a1);
        b2 = tbox(2'd1, b1);
        a3 = a2 ^ b2;
        b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
        a4 = tbox(2'd2, a3);
        b4 = tbox(2'd3, b3);
        return {b4, a4};
    endfunction

    typedef enum logic {S_INIT, S_SERVE} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [7:0]  tbl_q [256];
    logic [7:0]  rd_data;
    logic        accept;

    assign rd_data          = tbl_q[bus_if.in_data];
    assign init_done        = (state_q == S_SERVE);
    assign bus_if.in_ready  = (state_q == S_SERVE) && (!out_valid_q || bus_if.out_ready);
    assign accept           = bus_if.in_valid && bus_if.in_ready;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_data  = out_data_q;

    // Table is not reset; the sweep rewrites every entry before SERVE.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_INIT)
            tbl_q[fwd(cnt_q)] <= cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF)
                    state_d = S_SERVE;
            end
            default: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data;
                end else if (bus_if.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

`ifdef Q_BOX_INV_SELFCHECK_EN
    logic chk_err_q, chk_err_d;

    // Flags on the same edge that raises out_valid for the bad lookup.
    assign chk_err_d = chk_err_q | (accept && (fwd(rd_data) != bus_if.in_data));
    assign chk_err   = chk_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) chk_err_q <= 1'b0;
        else        chk_err_q <= chk_err_d;
    end
`endif

endmodule

// File: tb/tb_q_box_inv.sv
// Randomized bench for q_box_inv (q=0 and q=1 side by side) against a Twofish q-box reference.
module tb_q_box_inv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    q_box_inv_if bi0();
    q_box_inv_if bi1();
    logic init0, init1;
`ifdef Q_BOX_INV_SELFCHECK_EN
    logic cerr0, cerr1;
`endif

    q_box_inv #(.q(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus_if(bi0), .init_done(init0)
`ifdef Q_BOX_INV_SELFCHECK_EN
        , .chk_err(cerr0)
`endif
    );
    q_box_inv #(.q(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus_if(bi1), .init_done(init1)
`ifdef Q_BOX_INV_SELFCHECK_EN
        , .chk_err(cerr1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Twofish t-boxes [q][t][nibble]
    int tt [2][4][16] = '{
        '{'{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
          '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
          '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
          '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}},
        '{'{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
          '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
          '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
          '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}}};

    function automatic int ror4(int v);
        return ((v >> 1) | (v << 3)) % 16;
    endfunction

    function automatic int qref(int s, int x);
        int a, b, a2, b2;
        a  = x / 16;
        b  = x % 16;
        a2 = tt[s][0][a ^ b];
        b2 = tt[s][1][a ^ ror4(b) ^ ((8 * a) % 16)];
        a  = tt[s][2][a2 ^ b2];
        b  = tt[s][3][a2 ^ ror4(b2) ^ ((8 * a2) % 16)];
        return 16 * b + a;
    endfunction

    int inv [2][256];
    int sb[$];            // y values of accepted requests not yet consumed
    bit served = 1'b0;
    bit track = 1'b0;
    bit seen [2][256];

    task automatic drive(input logic iv, input logic [7:0] y, input logic ordy);
        bi0.in_valid = iv; bi0.in_data = y; bi0.out_ready = ordy;
        bi1.in_valid = iv; bi1.in_data = y; bi1.out_ready = ordy;
    endtask

    task automatic look(input int s, input logic rdy, input logic ov, input logic [7:0] od,
                        input logic exp_rdy);
        chk($sformatf("in_ready%0d", s), rdy, exp_rdy);
        chk($sformatf("out_valid%0d", s), ov, sb.size() != 0);
        if (sb.size() != 0) chk($sformatf("out_data%0d", s), od, inv[s][sb[0]]);
    endtask

    // One cycle: drive at negedge, check against the transaction model, advance.
    task automatic step(input logic iv, input logic [7:0] y, input logic ordy);
        logic exp_rdy;
        drive(iv, y, ordy);
        #1;
        exp_rdy = served && (sb.size() == 0 || ordy);
        look(0, bi0.in_ready, bi0.out_valid, bi0.out_data, exp_rdy);
        look(1, bi1.in_ready, bi1.out_valid, bi1.out_data, exp_rdy);
        if (sb.size() != 0 && ordy) begin
            if (track) begin
                seen[0][bi0.out_data] = 1'b1;
                seen[1][bi1.out_data] = 1'b1;
            end
            void'(sb.pop_front());
        end
        if (iv && exp_rdy) sb.push_back(int'(y));
        @(posedge clk); @(negedge clk);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 8'h00, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ov0", bi0.out_valid, 0); chk("rst_od0", bi0.out_data, 0);
        chk("rst_id0", init0, 0);         chk("rst_rdy0", bi0.in_ready, 0);
        chk("rst_ov1", bi1.out_valid, 0); chk("rst_id1", init1, 0);
        sb.delete();
        served = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full sweep with a request held on the bus; nothing may be accepted or produced.
    task automatic sweep();
        int bad = 0;
        drive(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            #1;
            if (bi0.in_ready || bi1.in_ready || bi0.out_valid || bi1.out_valid || init0 || init1)
                bad++;
            @(posedge clk); @(negedge clk);
        end
        chk("init_quiet", bad, 0);
        chk("init_done0", init0, 1);
        chk("init_done1", init1, 1);
        drive(1'b0, 8'h00, 1'b1);
        served = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt0, cnt1, prev;
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 256; x++) inv[s][qref(s, x)] = x;

        hold_reset();
        sweep();

        // known vectors: q0^-1(A9) = q1^-1(75) = 00
        step(1'b1, 8'hA9, 1'b1);
        chk("vec_q0", bi0.out_data, 8'h00);
        step(1'b1, 8'h75, 1'b1);
        chk("vec_q1", bi1.out_data, 8'h00);
        step(1'b0, 8'h00, 1'b1);

        // back-pressure: 0x00 result on dut0 held while a second request waits
        step(1'b1, 8'hA9, 1'b1);
        prev = int'(bi0.out_data);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h33, 1'b0);
        chk("stall_data", bi0.out_data, prev);
        step(1'b1, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // stream every byte at full rate
        track = 1'b1;
        for (int y = 0; y < 256; y++) step(1'b1, 8'(y), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        track = 1'b0;
        cnt0 = 0; cnt1 = 0;
        for (int v = 0; v < 256; v++) begin
            cnt0 += int'(seen[0][v]);
            cnt1 += int'(seen[1][v]);
        end
        chk("perm0", cnt0, 256);
        chk("perm1", cnt1, 256);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);

        // reset with a result pending, then reset again mid-sweep at count 100
        step(1'b1, 8'h5A, 1'b0);
        hold_reset();
        drive(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) @(posedge clk);
        hold_reset();
        sweep();
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        step(1'b0, 8'h00, 1'b1);

`ifdef Q_BOX_INV_SELFCHECK_EN
        chk("chk_clean0", cerr0, 0);
        chk("chk_clean1", cerr1, 0);
        dut0.tbl_q[8'h10] = ~8'(inv[0][16]);
        drive(1'b1, 8'h10, 1'b1);
        @(posedge clk); @(negedge clk);
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("chk_set", cerr0, 1);
        chk("chk_other", cerr1, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("chk_sticky", cerr0, 1);
        hold_reset();
        #1;
        chk("chk_rst", cerr0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
